// File: rtl/sm_rx_pkg.sv
// Shared constants for the serial-to-memory receiver: state codes, default widths
// and the terminal write address.
package sm_rx_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADR_W_DEF  = 2;

  typedef logic [2:0] state_t;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_RDY   = 3'd1;
  localparam logic [2:0] ST_RCV   = 3'd2;
  localparam logic [2:0] ST_WRITE = 3'd3;
  localparam logic [2:0] ST_ERR   = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  localparam int DONE_ADR_DEF = (1 << ADR_W_DEF) - 1;

  // Last address written before the receiver parks in DONE.
  function automatic int last_adr(input int adr_w);
    return (1 << adr_w) - 1;
  endfunction

endpackage

// File: rtl/sm_rx_shr.sv
// Serial-in parallel-out register: LSB-first bits enter at the MSB and move right,
// so after DATA_W shifts the first bit sits in bit 0.
module rx_shr
  import sm_rx_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              i_clear,
  input  logic              i_shift,
  input  logic              i_bit,
  output logic [DATA_W-1:0] o_data
);

  logic [DATA_W-1:0] r_data;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_data <= '0;
    end else if (i_clear) begin
      r_data <= '0;
    end else if (i_shift) begin
      r_data <= {i_bit, r_data[DATA_W-1:1]};
    end
  end

  assign o_data = r_data;

endmodule

// File: rtl/sm_rx.sv
// Serial word receiver that stores 2^ADR_W words into memory, then parks in DONE.
// Define SM_RX_VLD_CHK_EN to treat a tx_vld gap inside a word as a framing error.
module sm_rx
  import sm_rx_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADR_W  = ADR_W_DEF
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              rx_en,
  input  logic              tx_vld,
  input  logic              tx_data,
  output logic              rx_ready,
  output logic              wr_en,
  output logic [ADR_W-1:0]  wr_adr,
  output logic [DATA_W-1:0] wr_data,
  output logic              rx_finish,
  output logic              rx_err
);

  localparam int               CNT_W    = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
  localparam logic [ADR_W-1:0] LAST_ADR = ADR_W'(last_adr(ADR_W));

  state_t            r_state;
  state_t            w_state_next;
  logic [ADR_W-1:0]  r_adr;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_shift;
  logic              w_clear;
  logic [DATA_W-1:0] w_data;

  rx_shr #(
    .DATA_W (DATA_W)
  ) u_shr (
    .clk     (clk),
    .clr     (clr),
    .i_clear (w_clear),
    .i_shift (w_shift),
    .i_bit   (tx_data),
    .o_data  (w_data)
  );

  always_comb begin
    w_state_next = r_state;
    w_shift      = 1'b0;
    w_clear      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (rx_en) w_state_next = ST_RDY;
      end
      ST_RDY: begin
        if (tx_vld) begin
          w_shift      = 1'b1;
          w_state_next = ST_RCV;
        end
      end
      ST_RCV: begin
        if (tx_vld) begin
          w_shift = 1'b1;
          if (r_cnt == LAST_BIT) w_state_next = ST_WRITE;
        end
`ifdef SM_RX_VLD_CHK_EN
        else begin
          w_clear      = 1'b1;
          w_state_next = ST_ERR;
        end
`endif
      end
      ST_WRITE: begin
        // Word is consumed this cycle; clearing now leaves a clean register for the next one.
        w_clear      = 1'b1;
        w_state_next = (r_adr == LAST_ADR) ? ST_DONE : ST_RDY;
      end
      ST_ERR:  w_state_next = ST_RDY;
      ST_DONE: w_state_next = ST_DONE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state <= ST_IDLE;
      r_adr   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_clear) begin
        r_cnt <= '0;
      end else if (w_shift) begin
        r_cnt <= r_cnt + 1'b1;
      end
      // Address saturates at the terminal value; DONE is reached instead of wrapping.
      if (r_state == ST_WRITE && r_adr != LAST_ADR) begin
        r_adr <= r_adr + 1'b1;
      end
    end
  end

  assign rx_ready  = (r_state == ST_RDY);
  assign wr_en     = (r_state == ST_WRITE);
  assign wr_adr    = r_adr;
  assign wr_data   = w_data;
  assign rx_finish = (r_state == ST_DONE);

`ifdef SM_RX_VLD_CHK_EN
  assign rx_err = (r_state == ST_ERR);
`else
  assign rx_err = 1'b0;
`endif

endmodule
